// File: rtl/sq_rr_sched.sv
// Round-robin front end that shares one squaring datapath among NREQ requesters.
// An in-order tag queue remembers who issued each operand so results can be steered back.
module sq_rr_sched #(
    parameter int DATAW      = 16,
    parameter int NREQ       = 4,
    parameter int TAGQ_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ*DATAW-1:0]               req_data,
    output logic                                mul_in_valid,
    input  logic                                mul_in_ready,
    output logic [DATAW-1:0]                    mul_in_data,
    input  logic                                mul_out_valid,
    output logic                                mul_out_ready,
    input  logic [2*DATAW-1:0]                  mul_out_data,
    output logic [NREQ-1:0]                     rsp_valid,
    input  logic [NREQ-1:0]                     rsp_ready,
    output logic [2*DATAW-1:0]                  rsp_data,
    output logic [$clog2(TAGQ_DEPTH+1)-1:0]     outstanding,
    output logic                                busy,
    output logic                                err_orphan
);

    localparam int IDW  = $clog2(NREQ);
    localparam int PTRW = $clog2(TAGQ_DEPTH);
    localparam int CNTW = $clog2(TAGQ_DEPTH+1);

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            lock_q;
    logic [IDW-1:0]  lock_id_q;
    logic [IDW-1:0]  tagq_q [TAGQ_DEPTH];
    logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            err_orphan_q;

    logic            full, empty, any_elig, fire, pop;
    logic [NREQ-1:0] eligible;
    logic [IDW-1:0]  scan_id, grant_id, head_id;

    assign full     = (count_q == CNTW'(TAGQ_DEPTH));
    assign empty    = (count_q == '0);
    assign eligible = full ? '0 : req_valid;

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        scan_id  = rr_ptr_q;
        any_elig = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr_q) + k) % NREQ]) begin
                scan_id  = IDW'((int'(rr_ptr_q) + k) % NREQ);
                any_elig = 1'b1;
            end
        end
    end

    assign grant_id     = lock_q ? lock_id_q : scan_id;
    assign mul_in_valid = rst_n & (lock_q | any_elig);
    assign fire         = mul_in_valid & mul_in_ready;
    assign req_ready    = fire ? (NREQ'(1) << grant_id) : '0;
    assign mul_in_data  = req_data[grant_id*DATAW +: DATAW];
    assign rr_ptr_d     = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;

    // An empty queue means the result has no owner: accept and drop it.
    assign head_id       = tagq_q[rd_ptr_q];
    assign mul_out_ready = rst_n & (empty | rsp_ready[head_id]);
    assign rsp_valid     = (rst_n & mul_out_valid & ~empty) ? (NREQ'(1) << head_id) : '0;
    assign rsp_data      = mul_out_data;
    assign pop           = mul_out_valid & mul_out_ready & ~empty;

    always_comb begin
        count_d = count_q;
        if (fire && !pop)
            count_d = count_q + 1'b1;
        else if (!fire && pop)
            count_d = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            if (fire) begin
                rr_ptr_q <= rr_ptr_d;
                lock_q   <= 1'b0;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end else if (mul_in_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant_id;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (mul_out_valid && empty)
                err_orphan_q <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (fire)
            tagq_q[wr_ptr_q] <= grant_id;
    end

    assign outstanding = count_q;
    assign busy        = ~empty;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_sq_rr_sched.sv
// Directed bench for sq_rr_sched: a one-cycle squaring model behind the scheduler and
// a scoreboard monitor that matches every accepted response against hand-computed values.
module tb_sq_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_data;
    logic        mul_in_valid;
    logic        mul_in_ready;
    logic [15:0] mul_in_data;
    logic        mul_out_valid;
    logic        mul_out_ready;
    logic [31:0] mul_out_data;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  outstanding;
    logic        busy;
    logic        err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    sq_rr_sched #(.DATAW(16), .NREQ(4), .TAGQ_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .mul_in_valid (mul_in_valid),
        .mul_in_ready (mul_in_ready),
        .mul_in_data  (mul_in_data),
        .mul_out_valid(mul_out_valid),
        .mul_out_ready(mul_out_ready),
        .mul_out_data (mul_out_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .outstanding  (outstanding),
        .busy         (busy),
        .err_orphan   (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Squaring datapath model: result visible the cycle after the operand is accepted.
    logic signed [31:0] mq [16];
    logic [3:0] mwr = '0;
    logic [3:0] mrd = '0;
    logic       hold;
    logic       inj;
    logic       model_v;

    assign model_v       = (mwr != mrd) && !hold;
    assign mul_out_valid = model_v || inj;
    assign mul_out_data  = model_v ? mq[mrd] : 32'hDEAD_0000;

    always @(posedge clk) begin
        if (mul_in_valid && mul_in_ready) begin
            mq[mwr] <= $signed(mul_in_data) * $signed(mul_in_data);
            mwr     <= mwr + 4'd1;
        end
        if (model_v && mul_out_ready)
            mrd <= mrd + 4'd1;
    end

    typedef struct {
        logic [3:0]  oh;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int id, input logic [31:0] d);
        exp_t e;
        e.oh   = 4'b0001 << id;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every completed response handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && ((rsp_valid & rsp_ready) != 4'b0000)) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {60'd0, rsp_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_valid", {60'd0, rsp_valid}, {60'd0, e.oh});
                check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n        = 1'b0;
        req_valid    = 4'b0000;
        mul_in_ready = 1'b1;
        rsp_ready    = 4'b1111;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int fair_ids[6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] full_sq[4] = '{32'd100, 32'd121, 32'd144, 32'd169};

    initial begin
        rst_n        = 1'b0;
        req_valid    = 4'b1111;
        req_data     = '0;
        mul_in_ready = 1'b1;
        rsp_ready    = 4'b1111;
        hold         = 1'b0;
        inj          = 1'b0;

        // Reset state: handshake outputs forced low even with requests pending.
        @(negedge clk);
        check("rst_mul_in_valid", {63'd0, mul_in_valid}, 64'd0);
        check("rst_req_ready", {60'd0, req_ready}, 64'd0);
        check("rst_mul_out_ready", {63'd0, mul_out_ready}, 64'd0);
        check("rst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        check("rst_outstanding", {61'd0, outstanding}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err_orphan", {63'd0, err_orphan}, 64'd0);
        step();
        req_valid = 4'b0000;
        rst_n     = 1'b1;

        // Single request from requester 1, operand 3.
        step();
        req_valid        = 4'b0010;
        req_data[16 +: 16] = 16'd3;
        @(negedge clk);
        check("single_req_ready", {60'd0, req_ready}, 64'h2);
        check("single_in_valid", {63'd0, mul_in_valid}, 64'd1);
        check("single_in_data", {48'd0, mul_in_data}, 64'd3);
        expect_rsp(1, 32'd9);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("single_outstanding", {61'd0, outstanding}, 64'd1);
        check("single_busy", {63'd0, busy}, 64'd1);
        step();
        @(negedge clk);
        check("single_drained", {61'd0, outstanding}, 64'd0);

        // Fairness: all four requesters valid with operand -2.
        do_reset();
        step();
        req_valid = 4'b1111;
        req_data  = {4{16'hFFFE}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fair_grant", {60'd0, req_ready}, 64'd1 << fair_ids[i]);
            expect_rsp(fair_ids[i], 32'd4);
            step();
        end
        req_valid = 4'b0000;
        step();
        step();
        @(negedge clk);
        check("fair_drained", {61'd0, outstanding}, 64'd0);

        // Grant lock under stall.
        do_reset();
        step();
        req_valid          = 4'b0101;
        mul_in_ready       = 1'b0;
        req_data           = '0;
        req_data[0 +: 16]  = 16'd5;
        req_data[16 +: 16] = 16'hFFF9;
        req_data[32 +: 16] = 16'd100;
        @(negedge clk);
        check("stall_in_valid", {63'd0, mul_in_valid}, 64'd1);
        check("stall_req_ready", {60'd0, req_ready}, 64'd0);
        check("stall_data_1", {48'd0, mul_in_data}, 64'd5);
        step();
        req_valid = 4'b0111;
        @(negedge clk);
        check("stall_data_2", {48'd0, mul_in_data}, 64'd5);
        step();
        @(negedge clk);
        check("stall_data_3", {48'd0, mul_in_data}, 64'd5);
        step();
        mul_in_ready = 1'b1;
        @(negedge clk);
        check("stall_fire_0", {60'd0, req_ready}, 64'h1);
        expect_rsp(0, 32'd25);
        step();
        req_valid = 4'b0110;
        @(negedge clk);
        check("stall_then_1", {60'd0, req_ready}, 64'h2);
        expect_rsp(1, 32'd49);
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        check("stall_then_2", {60'd0, req_ready}, 64'h4);
        expect_rsp(2, 32'd10000);
        // rr_ptr is now 3; lock grant 0, then a new request at 3 must not steal it.
        step();
        req_valid    = 4'b0001;
        mul_in_ready = 1'b0;
        @(negedge clk);
        check("lock_wrap_data", {48'd0, mul_in_data}, 64'd5);
        step();
        req_valid          = 4'b1001;
        req_data[48 +: 16] = 16'd9;
        @(negedge clk);
        check("lock_vs_new", {48'd0, mul_in_data}, 64'd5);
        step();
        mul_in_ready = 1'b1;
        @(negedge clk);
        check("lock_fire_0", {60'd0, req_ready}, 64'h1);
        expect_rsp(0, 32'd25);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        check("lock_then_3", {60'd0, req_ready}, 64'h8);
        expect_rsp(3, 32'd81);
        step();
        req_valid = 4'b0000;
        step();
        step();
        @(negedge clk);
        check("lock_drained", {61'd0, outstanding}, 64'd0);

        // Full tag queue with responses back-pressured.
        do_reset();
        step();
        rsp_ready          = 4'b0000;
        req_valid          = 4'b1111;
        req_data[0 +: 16]  = 16'd10;
        req_data[16 +: 16] = 16'hFFF5;
        req_data[32 +: 16] = 16'd12;
        req_data[48 +: 16] = 16'hFFF3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_fill_grant", {60'd0, req_ready}, 64'd1 << i);
            expect_rsp(i, full_sq[i]);
            step();
        end
        @(negedge clk);
        check("full_in_valid", {63'd0, mul_in_valid}, 64'd0);
        check("full_req_ready", {60'd0, req_ready}, 64'd0);
        check("full_outstanding", {61'd0, outstanding}, 64'd4);
        check("full_head_visible", {60'd0, rsp_valid}, 64'h1);
        step();
        rsp_ready = 4'b1111;
        @(negedge clk);
        check("full_pop_blocks_push", {63'd0, mul_in_valid}, 64'd0);
        step();
        @(negedge clk);
        check("full_resume_grant", {60'd0, req_ready}, 64'h1);
        check("full_resume_outstanding", {61'd0, outstanding}, 64'd3);
        expect_rsp(0, 32'd100);
        step();
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        check("full_drained", {61'd0, outstanding}, 64'd0);

        // Orphan result with an empty tag queue.
        step();
        inj = 1'b1;
        @(negedge clk);
        check("orphan_out_ready", {63'd0, mul_out_ready}, 64'd1);
        check("orphan_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        check("orphan_not_yet", {63'd0, err_orphan}, 64'd0);
        step();
        inj = 1'b0;
        @(negedge clk);
        check("orphan_set", {63'd0, err_orphan}, 64'd1);
        step();
        step();
        @(negedge clk);
        check("orphan_sticky", {63'd0, err_orphan}, 64'd1);

        // Reset with three results outstanding.
        do_reset();
        @(negedge clk);
        check("orphan_cleared", {63'd0, err_orphan}, 64'd0);
        step();
        rsp_ready          = 4'b0000;
        req_valid          = 4'b0111;
        req_data           = '0;
        req_data[0 +: 16]  = 16'd2;
        req_data[16 +: 16] = 16'd3;
        req_data[32 +: 16] = 16'd4;
        step();
        step();
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("midrst_outstanding", {61'd0, outstanding}, 64'd3);
        step();
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", {60'd0, req_ready}, 64'd0);
        check("midrst_in_valid", {63'd0, mul_in_valid}, 64'd0);
        check("midrst_out_ready", {63'd0, mul_out_ready}, 64'd0);
        check("midrst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        check("midrst_outstanding0", {61'd0, outstanding}, 64'd0);
        step();
        rst_n        = 1'b1;
        mul_in_ready = 1'b0;
        @(negedge clk);
        check("post_rst_in_valid", {63'd0, mul_in_valid}, 64'd1);
        check("post_rst_grant0", {48'd0, mul_in_data}, 64'd2);
        check("post_rst_outstanding", {61'd0, outstanding}, 64'd0);
        check("post_rst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        step();
        @(negedge clk);
        check("post_rst_orphan", {63'd0, err_orphan}, 64'd1);
        step();
        req_valid = 4'b0000;
        step();
        step();
        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sq_rr_sched.md
# sq_rr_sched

Round-robin scheduler that shares one squaring datapath (DATAW-bit signed in, 2*DATAW-bit signed out, valid/ready on both sides) among NREQ requester streams. It sits between the requesters and the datapath. Accepted requests are issued to the datapath one per cycle. The granted requester ID is recorded in an in-order tag queue, and each returning result is steered back to the requester that issued it.

## Interface
- DATAW, 16, requester operand width (signed).
- NREQ, 4, number of requesters (2..8).
- TAGQ_DEPTH, 4, max results outstanding in the datapath (power of two, ≥2).

- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set.
- req_data  in  NREQ*DATAW  requester i operand at [i*DATAW +: DATAW].
- mul_in_valid  out  1  operand valid to datapath.
- mul_in_ready  in  1  datapath accepts operand.
- mul_in_data  out  DATAW  operand to datapath.
- mul_out_valid  in  1  datapath result valid.
- mul_out_ready  out  1  result accepted.
- mul_out_data  in  2*DATAW  datapath result.
- rsp_valid  out  NREQ  one-hot response valid.
- rsp_ready  in  NREQ  per-requester response ready.
- rsp_data  out  2*DATAW  shared response bus (pass-through of mul_out_data).
- outstanding  out  $clog2(TAGQ_DEPTH+1)  tag-queue occupancy.
- busy  out  1  outstanding != 0.
- err_orphan  out  1  sticky: result arrived with empty tag queue.

## Operation
- Eligible set is req_valid, gated to zero when the tag queue is full.
- Grant is the first eligible index at or after rr_ptr, scanning upward with wrap from NREQ-1 to 0.
- mul_in_valid is high when any requester is eligible or a grant is locked.
- mul_in_data is req_data of the granted index.
- req_ready[g] = mul_in_ready for the granted index g; all other bits are 0.
- Issue fire is mul_in_valid && mul_in_ready. On fire:
  - push g into the tag queue;
  - rr_ptr <= (g+1) mod NREQ;
  - clear the lock.
- Grant lock: when mul_in_valid && !mul_in_ready, register g. The same g is driven until fire, regardless of new requests.
- Requesters must hold req_valid and req_data stable until req_ready. This is a protocol requirement and is not checked.
- The datapath returns exactly one result per accepted operand, in issue order.
- Return side with queue non-empty:
  - head ID h = tag queue head;
  - rsp_valid = onehot(h) when mul_out_valid;
  - rsp_data = mul_out_data;
  - mul_out_ready = rsp_ready[h];
  - pop on mul_out_valid && mul_out_ready.
- Return side with queue empty:
  - mul_out_ready = 1, and the result is dropped;
  - rsp_valid = 0;
  - if mul_out_valid, err_orphan <= 1 and stays set until reset.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- When the queue is full, push is blocked even if a pop occurs that cycle, because eligibility uses registered full.
- There is no arithmetic in this block; data widths pass straight through.

## Timing
- Reset (async assert, sync release): rr_ptr=0, lock cleared, tag queue empty, outstanding=0, busy=0, err_orphan=0.
- While rst_n=0: req_ready, mul_in_valid, mul_out_ready and rsp_valid are forced to 0. mul_in_data and rsp_data are don't-care.
- Issue path is combinational, 0 cycles: req_valid to mul_in_valid and mul_in_ready to req_ready in the same cycle.
- Return path is combinational, 0 cycles: mul_out_valid to rsp_valid and rsp_ready to mul_out_ready.
- rr_ptr, lock, tag queue, outstanding and err_orphan update on the clk rising edge after fire.
- Throughput is one issue per cycle while the queue is not full and mul_in_ready=1.
- Reset mid-operation discards all outstanding tags. Results the datapath returns afterwards are orphans and set err_orphan.

## Test plan
- Single request: req_valid=4'b0010 with requester 1 operand 3, single-cycle squaring model → mul_in_data=3 in the same cycle, req_ready=4'b0010. One cycle later rsp_valid=4'b0010, rsp_data=9, outstanding returns to 0.
- Fairness: all four requesters hold valid with operand −2, mul_in_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles; every rsp_data=4, delivered to the matching one-hot rsp_valid.
- Lock under stall: req_valid=4'b0101, mul_in_ready=0 for 3 cycles. Raise req 1 in the second stall cycle → grant stays 0 throughout. When ready rises, req 0 fires, then grants run 1, then 2.
- Full queue: model holds results, rsp_ready=0 → after 4 issues mul_in_valid=0 and outstanding=4. Assert rsp_ready → 4 responses return in issue order, and issuing resumes the cycle after the first pop.
- Orphan: mul_out_valid=1 with outstanding=0 → mul_out_ready=1, rsp_valid=0, err_orphan=1 the next cycle and it stays set.
- Reset mid-operation: with outstanding=3, pull rst_n low → all valid/ready outputs are 0 immediately. After release, outstanding=0 and the first grant goes to index 0.
